// File: rtl/sync_fifo_flagged.sv
// sync_fifo_flagged: single-clock FIFO with threshold flags, ack/err handshakes, occupancy count, flush and optional FWFT read
module sync_fifo_flagged #(
   parameter int SIZE      = 8,
   parameter int DEPTH     = 4,
   parameter int AF_THRESH = (1 << DEPTH) - 1,
   parameter int AE_THRESH = 1,
   parameter int FWFT      = 0
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [SIZE-1:0]  din,
   input  logic             wen,
   input  logic             ren,
   input  logic             flush,
   output logic [SIZE-1:0]  dout,
   output logic             fifo_full,
   output logic             fifo_empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic             wr_ack,
   output logic             wr_err,
   output logic             rd_ack,
   output logic             rd_err,
   output logic [DEPTH:0]   data_count
);
   localparam logic [DEPTH:0] CAP = (DEPTH+1)'(1 << DEPTH);
   localparam logic [DEPTH:0] AF  = (DEPTH+1)'(AF_THRESH);
   localparam logic [DEPTH:0] AE  = (DEPTH+1)'(AE_THRESH);
   logic [SIZE-1:0] mem [1 << DEPTH];
   logic [DEPTH:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
   logic [SIZE-1:0] dout_q, dout_d, head;
   logic            wr_ack_q, wr_ack_d, wr_err_q, wr_err_d;
   logic            rd_ack_q, rd_ack_d, rd_err_q, rd_err_d;
   logic            wr_ok, rd_ok;
   assign fifo_full    = count_q == CAP;
   assign fifo_empty   = count_q == '0;
   assign almost_full  = count_q >= AF;
   assign almost_empty = count_q <= AE;
   assign data_count   = count_q;
   assign wr_ack       = wr_ack_q;
   assign wr_err       = wr_err_q;
   assign rd_ack       = rd_ack_q;
   assign rd_err       = rd_err_q;
   assign head         = mem[rd_ptr_q[DEPTH-1:0]];
   assign dout         = (FWFT != 0) ? head : dout_q;
   always_comb begin
      wr_ok    = wen & ~fifo_full & ~flush;
      rd_ok    = ren & ~fifo_empty & ~flush;
      wr_ack_d = wr_ok;
      wr_err_d = wen & fifo_full & ~flush;
      rd_ack_d = rd_ok;
      rd_err_d = ren & fifo_empty & ~flush;
      wr_ptr_d = flush ? '0 : wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = flush ? '0 : rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = flush ? '0 :
                 (wr_ok & ~rd_ok) ? count_q + 1'b1 :
                 (rd_ok & ~wr_ok) ? count_q - 1'b1 : count_q;
      dout_d   = rd_ok ? head : dout_q;
   end
   always_ff @(posedge clk_i) begin
      if (wr_ok) mem[wr_ptr_q[DEPTH-1:0]] <= din;
   end
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= '0;
         wr_ack_q <= 1'b0;
         wr_err_q <= 1'b0;
         rd_ack_q <= 1'b0;
         rd_err_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         dout_q   <= dout_d;
         wr_ack_q <= wr_ack_d;
         wr_err_q <= wr_err_d;
         rd_ack_q <= rd_ack_d;
         rd_err_q <= rd_err_d;
      end
   end
endmodule

// File: doc/sync_fifo_flagged.md
Name: sync_fifo_flagged

Overview:
Single-clock, parametrised successor to the team's custom async FIFO, for blocks that share one clock domain.
- Adds programmable almost-full/almost-empty thresholds, write/read ack and error handshakes, an occupancy count, a synchronous flush and a selectable first-word-fall-through (FWFT) read mode.
- Sits between same-clock producer/consumer stages; drop-in for custom_async_fifo where no CDC is needed.

Parameters:
SIZE, 8, data width in bits (1..64)
DEPTH, 4, log2 of entry count; capacity N = 2**DEPTH (DEPTH 1..10)
AF_THRESH, 2**DEPTH-1, almost_full asserts when count >= AF_THRESH (1..N)
AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH (0..N-1)
FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through

Ports:
clk_i  in  1  single clock, all logic on rising edge
rst_n_i  in  1  asynchronous active-low reset; deassertion synchronous to clk_i externally
din  in  SIZE  write data
wen  in  1  write request
ren  in  1  read request (standard: request; FWFT: pop/acknowledge head)
flush  in  1  synchronous clear of contents
dout  out  SIZE  read data
fifo_full  out  1  count == N
fifo_empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
wr_ack  out  1  registered, previous-cycle write accepted
wr_err  out  1  registered, previous-cycle write rejected (full)
rd_ack  out  1  registered, previous-cycle read accepted
rd_err  out  1  registered, previous-cycle read rejected (empty)
data_count  out  DEPTH+1  current occupancy 0..N

Behaviour:
- Storage: N x SIZE array. wr_ptr/rd_ptr are DEPTH+1 bits; the low DEPTH bits address the array, and the MSB resolves wrap-around. count is a registered DEPTH+1-bit value.
- Reset (rst_n_i=0, asynchronous): pointers=0, count=0, fifo_empty=1, fifo_full=0, almost_empty=1, almost_full=0, all ack/err=0, dout=0. Array contents are not reset.
- Accept rules (evaluated on registered count at the edge):
  - Write accepted iff wen & !fifo_full.
  - Read accepted iff ren & !fifo_empty.
  - A full FIFO never accepts a write, even with a concurrent read.
  - An empty FIFO never accepts a read, even with a concurrent write.
- count update: +1 write only, -1 read only, unchanged on both or neither.
- Flags are decoded from registered count, so they change on the same edge as count and are valid 0 cycles after that edge.
- Handshake: wr_ack / wr_err pulse for exactly one cycle, the cycle after the edge on which wen was sampled (accepted / rejected). rd_ack / rd_err follow the same rule for ren. Rejected requests change no state.
- Standard mode (FWFT=0):
  - dout is registered and loads mem[rd_ptr] on an accepted read, so it is valid in the same cycle as rd_ack.
  - dout holds otherwise, including on rd_err.
- FWFT mode (FWFT=1):
  - dout = mem[rd_ptr[DEPTH-1:0]] continuously and is valid whenever fifo_empty=0.
  - An accepted ren advances to the next entry after the edge.
  - A write to an empty FIFO is visible on dout the cycle after the write edge, when fifo_empty falls.
  - dout is don't-care while empty.
- flush=1 at an edge:
  - Pointers and count go to 0, with flags as at reset.
  - flush overrides wen/ren that cycle; all ack/err are 0 the next cycle.
  - dout holds in standard mode.
- Wrap-around: pointers roll over modulo 2N with no bubble; back-to-back full-rate writes then reads sustain one op per cycle.

Test Plan:
1. SIZE=32, DEPTH=2, AF_THRESH=3, AE_THRESH=1, FWFT=0. Reset, then 5 consecutive wen writing 0xA0..0xA4 → wr_ack 4 pulses; fifo_full=1 after 4th edge; 5th → wr_err=1, data_count stays 4; almost_full=1 from count 3; almost_empty=0 from count 2.
2. Same config, then 5 consecutive ren → dout 0xA0,0xA1,0xA2,0xA3 with rd_ack; 5th → rd_err=1, dout holds 0xA3; fifo_empty=1, almost_empty=1 at count<=1.
3. count=2, wen+ren same cycle for 10 cycles with incrementing data → data_count stays 2, no err, output order preserved across pointer wrap (pointers pass 7→0).
4. Full (count=4), wen+ren same cycle → read accepted, write rejected (wr_err=1, rd_ack=1), count 3. Empty, wen+ren → write accepted, rd_err=1, count 1.
5. FWFT=1: write 0x55 into empty → dout=0x55 once fifo_empty=0 without ren; ren → fifo_empty=1, rd_ack=1.
6. count=3, assert flush with wen=1; then assert rst_n_i=0 mid-stream between edges → after flush count=0, fifo_empty=1, no wr_ack; reset drives all outputs to reset values immediately, without waiting for a clock edge.
